muldiv_unit: RTL

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It supports signed and unsigned multiply and divide, MTHI/MTLO writes, a busy/done handshake toward the hazard unit, and a flush that cancels an operation in flight. It sits beside the main ALU in the execute stage. The decoder's `hien`/`loen`-style controls become an `op` code plus `start`. HI/LO read paths (MFHI/MFLO) are driven from the `hi`/`lo` outputs.

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative radix-2 multiply/divide unit with architectural HI/LO.
// Revision : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [2:0] c_op_mult  = 3'b000;
    localparam logic [2:0] c_op_multu = 3'b001;
    localparam logic [2:0] c_op_div   = 3'b010;
    localparam logic [2:0] c_op_divu  = 3'b011;
    localparam logic [2:0] c_op_mthi  = 3'b100;
    localparam logic [2:0] c_op_mtlo  = 3'b101;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               w_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff, w_div_rem;
    logic [2*WIDTH-1:0] w_step, w_prod;
    logic [WIDTH-1:0]   w_quot_mag, w_rem_mag, w_quot, w_rem;

    assign w_signed = (op == c_op_mult) || (op == c_op_div);
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -a : a;
    assign w_abs_b  = w_b_neg ? -b : b;

    // Multiply: add multiplicand into the upper half, then shift the whole product right.
    assign w_addend  = acc_q[0] ? opnd_q : '0;
    assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    // Divide: acc holds {remainder, remaining dividend bits / quotient bits}.
    assign w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, opnd_q};
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - opnd_q;
    assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];

    assign w_step = is_div_q ? {w_div_rem, acc_q[WIDTH-2:0], w_div_ge}
                             : {w_mul_sum, acc_q[WIDTH-1:1]};

    assign w_prod     = neg_lo_q ? -acc_q : acc_q;
    assign w_quot_mag = acc_q[WIDTH-1:0];
    assign w_rem_mag  = acc_q[2*WIDTH-1:WIDTH];
    assign w_quot     = neg_lo_q ? -w_quot_mag : w_quot_mag;
    assign w_rem      = neg_hi_q ? -w_rem_mag : w_rem_mag;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        c_op_mult, c_op_multu, c_op_div, c_op_divu: begin
                            state_d  = S_RUN;
                            busy_d   = 1'b1;
                            cnt_d    = '0;
                            is_div_d = op[1];
                            opnd_d   = op[1] ? w_abs_b : w_abs_a;
                            acc_d    = {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                            // A zero divisor keeps the all-ones quotient unsigned while
                            // the remainder sign restores the raw dividend into HI.
                            neg_lo_d = op[1] ? ((w_a_neg ^ w_b_neg) & (b != '0))
                                             : (w_a_neg ^ w_b_neg);
                            neg_hi_d = op[1] & w_a_neg;
                        end
                        c_op_mthi: hi_d = a;
                        c_op_mtlo: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = w_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == c_last) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = w_rem;
                        lo_d = w_quot;
                    end else begin
                        hi_d = w_prod[2*WIDTH-1:WIDTH];
                        lo_d = w_prod[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
